// File: rtl/tx_symbol_arbiter.sv
// Slot-based arbiter that merges per-channel sync/async 9-bit symbol FIFOs into one symbol stream.
// One symbol leaves every DIV clocks. Sync traffic takes priority, and idle slots are filled with K_IDLE.
module tx_symbol_arbiter #(
   parameter int         CHANNELS       = 2,
   parameter int         DIV            = 5,
   parameter int         SYNC_HOLD      = 2,
   parameter int         ASYNC_HOLD     = 8,
   parameter logic [8:0] K_IDLE         = 9'h1BC,
   parameter logic [8:0] TIMESTAMP_CODE = 9'h000
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [CHANNELS-1:0]     chan_en_i,
   input  logic [CHANNELS-1:0]     sync_empty_i,
   input  logic [9*CHANNELS-1:0]   sync_data_i,
   output logic [CHANNELS-1:0]     sync_re_o,
   input  logic [CHANNELS-1:0]     async_empty_i,
   input  logic [9*CHANNELS-1:0]   async_data_i,
   output logic [CHANNELS-1:0]     async_re_o,
   output logic [8:0]              sym_o,
   output logic                    sym_stb_o,
   output logic                    grant_sync_o,
   output logic [2:0]              grant_ch_o,
   output logic                    ts_o
);

   typedef enum logic {
      GrantAsync = 1'b0,
      GrantSync  = 1'b1
   } grantClass_e;

   localparam logic [3:0] LastCnt     = 4'(DIV - 1);
   localparam logic [3:0] EmitLoadCnt = 4'(DIV - 2);
   localparam logic [3:0] ReadCnt     = 4'd1;
   localparam logic [3:0] CaptureCnt  = 4'd2;
   localparam logic [3:0] SyncHold    = 4'(SYNC_HOLD);
   localparam logic [3:0] AsyncHold   = 4'(ASYNC_HOLD);

   // Successor of a channel index, wrapping at CHANNELS.
   function automatic logic [2:0] nextCh(input logic [2:0] ch);
      logic [2:0] res;
      res = 3'd0;
      if (int'(ch) < CHANNELS - 1) begin
         res = ch + 3'd1;
      end
      return res;
   endfunction

   // Returns {found, index} of the first set bit at or after start, wrapping modulo CHANNELS.
   function automatic logic [3:0] findFirst(input logic [7:0] avail, input logic [2:0] start);
      logic [3:0] res;
      int         idx;
      res = 4'd0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         idx = (int'(start) + i) % CHANNELS;
         if (avail[3'(idx)]) begin
            res = {1'b1, 3'(idx)};
         end
      end
      return res;
   endfunction

   logic [3:0]  cnt_q, cnt_d;
   grantClass_e grantClass_q, grantClass_d;
   logic [2:0]  grantCh_q, grantCh_d;
   logic [2:0]  asyncLast_q, asyncLast_d;
   logic [2:0]  syncRr_q, syncRr_d;
   logic [3:0]  idleCnt_q, idleCnt_d;
   logic [8:0]  pending_q, pending_d;
   logic        readDone_q, readDone_d;
   logic        firstSlot_q, firstSlot_d;
   logic [8:0]  sym_q, sym_d;
   logic        symStb_q, symStb_d;
   logic        ts_q, ts_d;

   logic [7:0]  syncAvail8;
   logic [7:0]  asyncAvail8;
   logic        curAvail;
   logic        doRead;
   logic [7:0]  reOneHot8;
   logic [8:0]  grantData;
   logic [3:0]  syncRrPick;
   logic [3:0]  syncNextPick;
   logic [3:0]  asyncNextPick;

   // A disabled channel looks empty to both the read and the arbitration logic.
   assign syncAvail8  = 8'(~sync_empty_i & chan_en_i);
   assign asyncAvail8 = 8'(~async_empty_i & chan_en_i);
   assign curAvail    = (grantClass_q == GrantSync) ? syncAvail8[grantCh_q] : asyncAvail8[grantCh_q];

   // No reads in the first slot after reset so that the first strobe carries K_IDLE.
   assign doRead    = (cnt_q == ReadCnt) && curAvail && !firstSlot_q;
   assign reOneHot8 = 8'(doRead) << grantCh_q;
   assign sync_re_o  = (grantClass_q == GrantSync)  ? CHANNELS'(reOneHot8) : '0;
   assign async_re_o = (grantClass_q == GrantAsync) ? CHANNELS'(reOneHot8) : '0;

   assign syncRrPick    = findFirst(syncAvail8, syncRr_q);
   assign syncNextPick  = findFirst(syncAvail8, nextCh(grantCh_q));
   assign asyncNextPick = findFirst(asyncAvail8, nextCh(grantCh_q));

   always_comb begin
      grantData = 9'h000;
      for (int c = 0; c < CHANNELS; c++) begin
         if (grantCh_q == 3'(c)) begin
            grantData = (grantClass_q == GrantSync) ? sync_data_i[9*c +: 9] : async_data_i[9*c +: 9];
         end
      end
   end

   always_comb begin
      cnt_d        = (cnt_q == LastCnt) ? 4'd0 : cnt_q + 4'd1;
      grantClass_d = grantClass_q;
      grantCh_d    = grantCh_q;
      asyncLast_d  = asyncLast_q;
      syncRr_d     = syncRr_q;
      idleCnt_d    = idleCnt_q;
      pending_d    = pending_q;
      readDone_d   = doRead;
      firstSlot_d  = firstSlot_q;
      sym_d        = sym_q;
      symStb_d     = 1'b0;
      ts_d         = 1'b0;

      if (cnt_q == LastCnt) begin
         firstSlot_d = 1'b0;
      end

      if (cnt_q == CaptureCnt) begin
         if (readDone_q) begin
            pending_d = grantData;
            idleCnt_d = 4'd0;
         end else begin
            pending_d = K_IDLE;
            if (idleCnt_q != 4'd15) begin
               idleCnt_d = idleCnt_q + 4'd1;
            end
         end
      end

      // Load on the edge before the emit phase, so the strobe is high while cnt == DIV-1.
      if (cnt_q == EmitLoadCnt) begin
         sym_d    = pending_d;
         symStb_d = 1'b1;
         ts_d     = (pending_d == TIMESTAMP_CODE);
      end

      if (cnt_q == LastCnt) begin
         case (grantClass_q)
            GrantAsync: begin
               if (syncAvail8 != 8'd0) begin
                  asyncLast_d  = grantCh_q;
                  grantClass_d = GrantSync;
                  grantCh_d    = syncRrPick[2:0];
                  idleCnt_d    = 4'd0;
               end else if (!curAvail && !(idleCnt_q < AsyncHold) && asyncNextPick[3]) begin
                  grantCh_d = asyncNextPick[2:0];
                  idleCnt_d = 4'd0;
               end
            end
            GrantSync: begin
               if (!curAvail && !(idleCnt_q < SyncHold)) begin
                  syncRr_d  = nextCh(grantCh_q);
                  idleCnt_d = 4'd0;
                  if (syncNextPick[3]) begin
                     grantCh_d = syncNextPick[2:0];
                  end else begin
                     grantClass_d = GrantAsync;
                     grantCh_d    = asyncLast_q;
                  end
               end
            end
            default: begin
               grantClass_d = GrantAsync;
               grantCh_d    = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q        <= 4'd0;
         grantClass_q <= GrantAsync;
         grantCh_q    <= 3'd0;
         asyncLast_q  <= 3'd0;
         syncRr_q     <= 3'd0;
         idleCnt_q    <= 4'd0;
         pending_q    <= K_IDLE;
         readDone_q   <= 1'b0;
         firstSlot_q  <= 1'b1;
         sym_q        <= K_IDLE;
         symStb_q     <= 1'b0;
         ts_q         <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         grantClass_q <= grantClass_d;
         grantCh_q    <= grantCh_d;
         asyncLast_q  <= asyncLast_d;
         syncRr_q     <= syncRr_d;
         idleCnt_q    <= idleCnt_d;
         pending_q    <= pending_d;
         readDone_q   <= readDone_d;
         firstSlot_q  <= firstSlot_d;
         sym_q        <= sym_d;
         symStb_q     <= symStb_d;
         ts_q         <= ts_d;
      end
   end

   assign sym_o        = sym_q;
   assign sym_stb_o    = symStb_q;
   assign ts_o         = ts_q;
   assign grant_sync_o = (grantClass_q == GrantSync);
   assign grant_ch_o   = grantCh_q;

endmodule

// File: tb/tb_tx_symbol_arbiter.sv
// Directed bench for tx_symbol_arbiter (CHANNELS=2, DIV=5), driving small FIFO models on each side.
// Each table record describes one symbol slot: what is pushed at its start and what must come out.
module tb_tx_symbol_arbiter;

   localparam int DIV = 5;

   logic        clk_i;
   logic        rst_i;
   logic [1:0]  chan_en_i;
   logic [1:0]  sync_empty_i;
   logic [17:0] sync_data_i;
   logic [1:0]  sync_re_o;
   logic [1:0]  async_empty_i;
   logic [17:0] async_data_i;
   logic [1:0]  async_re_o;
   logic [8:0]  sym_o;
   logic        sym_stb_o;
   logic        grant_sync_o;
   logic [2:0]  grant_ch_o;
   logic        ts_o;

   int checks = 0;
   int errors = 0;

   tx_symbol_arbiter #(
      .CHANNELS(2), .DIV(DIV), .SYNC_HOLD(2), .ASYNC_HOLD(8),
      .K_IDLE(9'h1BC), .TIMESTAMP_CODE(9'h000)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .chan_en_i(chan_en_i),
      .sync_empty_i(sync_empty_i), .sync_data_i(sync_data_i), .sync_re_o(sync_re_o),
      .async_empty_i(async_empty_i), .async_data_i(async_data_i), .async_re_o(async_re_o),
      .sym_o(sym_o), .sym_stb_o(sym_stb_o), .grant_sync_o(grant_sync_o),
      .grant_ch_o(grant_ch_o), .ts_o(ts_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // FIFO models: data appears one clock after the read enable.
   logic [8:0] sMem [2][32];
   logic [8:0] aMem [2][32];
   int sWr[2] = '{0, 0};
   int sRd[2] = '{0, 0};
   int aWr[2] = '{0, 0};
   int aRd[2] = '{0, 0};
   logic [8:0] sData[2] = '{9'h0, 9'h0};
   logic [8:0] aData[2] = '{9'h0, 9'h0};

   assign sync_empty_i  = {sWr[1] == sRd[1], sWr[0] == sRd[0]};
   assign async_empty_i = {aWr[1] == aRd[1], aWr[0] == aRd[0]};
   assign sync_data_i   = {sData[1], sData[0]};
   assign async_data_i  = {aData[1], aData[0]};

   always @(posedge clk_i) begin
      for (int c = 0; c < 2; c++) begin
         if (sync_re_o[c]) begin
            sData[c] <= sMem[c][sRd[c] % 32];
            sRd[c]   <= sRd[c] + 1;
         end
         if (async_re_o[c]) begin
            aData[c] <= aMem[c][aRd[c] % 32];
            aRd[c]   <= aRd[c] + 1;
         end
      end
   end

   // pushSel: 0 none, 1 async ch0, 2 async ch1, 3 sync ch0, 4 sync ch1
   typedef struct {
      logic [1:0] chanEn;
      int         pushSel;
      int         pushN;
      logic [8:0] pushBase;
      logic [1:0] expReS;
      logic [1:0] expReA;
      logic [8:0] expSym;
      logic       expTs;
      logic       expGs;
      logic [2:0] expGc;
   } slotVec_t;

   slotVec_t vecs[29];

   function automatic slotVec_t mk(input logic [1:0] en, input int sel, input int n, input logic [8:0] base,
                                   input logic [1:0] reS, input logic [1:0] reA, input logic [8:0] sym,
                                   input logic ts, input logic gs, input logic [2:0] gc);
      slotVec_t v;
      v.chanEn = en; v.pushSel = sel; v.pushN = n; v.pushBase = base;
      v.expReS = reS; v.expReA = reA; v.expSym = sym; v.expTs = ts; v.expGs = gs; v.expGc = gc;
      return v;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Pushes n symbols base, base+0x11, ... into the selected FIFO.
   task automatic pushSyms(input int sel, input int n, input logic [8:0] base);
      logic [8:0] val;
      val = base;
      for (int k = 0; k < n; k++) begin
         case (sel)
            1: begin aMem[0][aWr[0] % 32] = val; aWr[0]++; end
            2: begin aMem[1][aWr[1] % 32] = val; aWr[1]++; end
            3: begin sMem[0][sWr[0] % 32] = val; sWr[0]++; end
            4: begin sMem[1][sWr[1] % 32] = val; sWr[1]++; end
            default: ;
         endcase
         val = val + 9'h011;
      end
   endtask

   task automatic applyStimulus(input slotVec_t v);
      chan_en_i = v.chanEn;
      pushSyms(v.pushSel, v.pushN, v.pushBase);
   endtask

   // Runs one slot from a cnt==0 negedge; samples cnt = 1,2,3,4,0.
   task automatic runSlot(output logic [1:0] reS, output logic [1:0] reA, output logic [8:0] sym,
                          output logic ts, output logic stray);
      reS = '0; reA = '0; sym = '0; ts = 1'b0; stray = 1'b0;
      for (int k = 0; k < DIV; k++) begin
         @(negedge clk_i);
         if (k == 0) begin
            reS = sync_re_o;
            reA = async_re_o;
         end else if (sync_re_o != 2'b00 || async_re_o != 2'b00) begin
            stray = 1'b1;
         end
         if (k == DIV - 2) begin
            if (!sym_stb_o) stray = 1'b1;
            sym = sym_o;
            ts  = ts_o;
         end else if (sym_stb_o || ts_o) begin
            stray = 1'b1;
         end
         if (k == DIV - 1 && sym_o != sym) stray = 1'b1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [1:0] eReS, input logic [1:0] eReA,
                              input logic [8:0] eSym, input logic eTs, input logic eGs, input logic [2:0] eGc);
      logic [1:0] reS, reA;
      logic [8:0] sym;
      logic       ts, stray;
      runSlot(reS, reA, sym, ts, stray);
      checkVal({tag, " sync_re"}, 32'(reS), 32'(eReS));
      checkVal({tag, " async_re"}, 32'(reA), 32'(eReA));
      checkVal({tag, " sym"}, 32'(sym), 32'(eSym));
      checkVal({tag, " ts"}, 32'(ts), 32'(eTs));
      checkVal({tag, " stray"}, 32'(stray), 32'd0);
      checkVal({tag, " grant_sync"}, 32'(grant_sync_o), 32'(eGs));
      checkVal({tag, " grant_ch"}, 32'(grant_ch_o), 32'(eGc));
   endtask

   initial begin
      logic [1:0] dReS, dReA;
      logic [8:0] dSym;
      logic       dTs, dStray;
      int         nSlots;
      logic       found;

      vecs[0]  = mk(2'b11, 0, 0, 9'h000, 2'b00, 2'b00, 9'h1BC, 0, 0, 0);
      vecs[1]  = mk(2'b11, 1, 3, 9'h011, 2'b00, 2'b01, 9'h011, 0, 0, 0);
      vecs[2]  = mk(2'b11, 0, 0, 9'h000, 2'b00, 2'b01, 9'h022, 0, 0, 0);
      vecs[3]  = mk(2'b11, 0, 0, 9'h000, 2'b00, 2'b01, 9'h033, 0, 0, 0);
      vecs[4]  = mk(2'b11, 0, 0, 9'h000, 2'b00, 2'b00, 9'h1BC, 0, 0, 0);
      vecs[5]  = mk(2'b10, 1, 1, 9'h066, 2'b00, 2'b00, 9'h1BC, 0, 0, 0);
      vecs[6]  = mk(2'b10, 0, 0, 9'h000, 2'b00, 2'b00, 9'h1BC, 0, 0, 0);
      vecs[7]  = mk(2'b11, 0, 0, 9'h000, 2'b00, 2'b01, 9'h066, 0, 0, 0);
      vecs[8]  = mk(2'b11, 1, 1, 9'h000, 2'b00, 2'b01, 9'h000, 1, 0, 0);
      vecs[9]  = mk(2'b11, 1, 3, 9'h044, 2'b00, 2'b01, 9'h044, 0, 0, 0);
      vecs[10] = mk(2'b11, 4, 2, 9'h101, 2'b00, 2'b01, 9'h055, 0, 1, 1);
      vecs[11] = mk(2'b11, 0, 0, 9'h000, 2'b10, 2'b00, 9'h101, 0, 1, 1);
      vecs[12] = mk(2'b11, 0, 0, 9'h000, 2'b10, 2'b00, 9'h112, 0, 1, 1);
      vecs[13] = mk(2'b11, 0, 0, 9'h000, 2'b00, 2'b00, 9'h1BC, 0, 1, 1);
      vecs[14] = mk(2'b11, 0, 0, 9'h000, 2'b00, 2'b00, 9'h1BC, 0, 0, 0);
      vecs[15] = mk(2'b11, 0, 0, 9'h000, 2'b00, 2'b01, 9'h066, 0, 0, 0);
      vecs[16] = mk(2'b11, 3, 4, 9'h0A0, 2'b00, 2'b00, 9'h1BC, 0, 1, 0);
      vecs[17] = mk(2'b11, 4, 4, 9'h140, 2'b01, 2'b00, 9'h0A0, 0, 1, 0);
      vecs[18] = mk(2'b11, 0, 0, 9'h000, 2'b01, 2'b00, 9'h0B1, 0, 1, 0);
      vecs[19] = mk(2'b11, 0, 0, 9'h000, 2'b01, 2'b00, 9'h0C2, 0, 1, 0);
      vecs[20] = mk(2'b11, 0, 0, 9'h000, 2'b01, 2'b00, 9'h0D3, 0, 1, 0);
      vecs[21] = mk(2'b11, 0, 0, 9'h000, 2'b00, 2'b00, 9'h1BC, 0, 1, 0);
      vecs[22] = mk(2'b11, 0, 0, 9'h000, 2'b00, 2'b00, 9'h1BC, 0, 1, 1);
      vecs[23] = mk(2'b11, 0, 0, 9'h000, 2'b10, 2'b00, 9'h140, 0, 1, 1);
      vecs[24] = mk(2'b11, 0, 0, 9'h000, 2'b10, 2'b00, 9'h151, 0, 1, 1);
      vecs[25] = mk(2'b11, 0, 0, 9'h000, 2'b10, 2'b00, 9'h162, 0, 1, 1);
      vecs[26] = mk(2'b11, 0, 0, 9'h000, 2'b10, 2'b00, 9'h173, 0, 1, 1);
      vecs[27] = mk(2'b11, 0, 0, 9'h000, 2'b00, 2'b00, 9'h1BC, 0, 1, 1);
      vecs[28] = mk(2'b11, 0, 0, 9'h000, 2'b00, 2'b00, 9'h1BC, 0, 0, 0);

      rst_i     = 1'b0;
      chan_en_i = 2'b11;
      repeat (3) @(negedge clk_i);
      checkVal("reset sym", 32'(sym_o), 32'h1BC);
      checkVal("reset stb", 32'(sym_stb_o), 32'd0);
      checkVal("reset ts", 32'(ts_o), 32'd0);
      checkVal("reset re", 32'({sync_re_o, async_re_o}), 32'd0);
      checkVal("reset grant", 32'({grant_sync_o, grant_ch_o}), 32'd0);
      rst_i = 1'b1;

      for (int i = 0; i < 29; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d", i), vecs[i].expReS, vecs[i].expReA, vecs[i].expSym,
                     vecs[i].expTs, vecs[i].expGs, vecs[i].expGc);
      end

      // Async ch0 idle, ch1 waiting: the grant moves after ASYNC_HOLD empty slots.
      pushSyms(2, 1, 9'h0E7);
      nSlots = 0;
      found  = 1'b0;
      for (int s = 0; s < 12 && !found; s++) begin
         runSlot(dReS, dReA, dSym, dTs, dStray);
         nSlots++;
         if (!grant_sync_o && grant_ch_o == 3'd1) found = 1'b1;
      end
      checkVal("async hold slots", 32'(nSlots), 32'd8);
      checkOutput("ahold read", 2'b00, 2'b10, 9'h0E7, 0, 0, 1);

      // Sync burst from async ch1 must return to async ch1.
      pushSyms(3, 1, 9'h1F0);
      checkOutput("ret0", 2'b00, 2'b00, 9'h1BC, 0, 1, 0);
      checkOutput("ret1", 2'b01, 2'b00, 9'h1F0, 0, 1, 0);
      checkOutput("ret2", 2'b00, 2'b00, 9'h1BC, 0, 1, 0);
      checkOutput("ret3", 2'b00, 2'b00, 9'h1BC, 0, 0, 1);

      // Reset in the middle of a slot with a read in flight.
      pushSyms(2, 2, 9'h077);
      checkOutput("pre rst", 2'b00, 2'b10, 9'h077, 0, 0, 1);
      @(negedge clk_i);
      checkVal("mid re", 32'(async_re_o), 32'h2);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      checkVal("rst sym", 32'(sym_o), 32'h1BC);
      checkVal("rst stb", 32'(sym_stb_o), 32'd0);
      checkVal("rst ts", 32'(ts_o), 32'd0);
      checkVal("rst re", 32'({sync_re_o, async_re_o}), 32'd0);
      checkVal("rst grant", 32'({grant_sync_o, grant_ch_o}), 32'd0);
      pushSyms(1, 1, 9'h099);
      @(negedge clk_i);
      rst_i = 1'b1;
      checkOutput("post rst0", 2'b00, 2'b00, 9'h1BC, 0, 0, 0);
      checkOutput("post rst1", 2'b00, 2'b01, 9'h099, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_symbol_arbiter.md
Name: tx_symbol_arbiter

Overview:
- Parametrised successor to the two-link TX framing arbiter.
- Multiplexes CHANNELS pairs of sync/async 9-bit symbol FIFOs onto one symbol stream, one symbol every DIV clocks, ahead of the 8b10b encoder/serializer.
- Sync traffic has strict priority, with round-robin between sync channels and between async channels; per-channel enable masking; hold windows are parametrised; idle slots are filled with K_IDLE.
- Flags each emitted timestamp symbol.

Parameters:
- CHANNELS, 2, number of sync/async FIFO pairs (1..8).
- DIV, 5, clocks per symbol slot (4..16).
- SYNC_HOLD, 2, empty slots a sync grant is held before release (0..15).
- ASYNC_HOLD, 8, empty slots an async grant is held before release (0..15).
- K_IDLE, 9'h1BC, fill symbol; bit 8 is the K flag.
- TIMESTAMP_CODE, 9'h000, symbol value that raises ts_o.

Ports:
- clk_i  in  1  symbol clock.
- rst_i  in  1  asynchronous reset, active-low.
- chan_en_i  in  CHANNELS  per-channel enable; a disabled channel is treated as empty in both classes.
- sync_empty_i  in  CHANNELS  sync FIFO empty flags.
- sync_data_i  in  9*CHANNELS  sync FIFO read data; channel c occupies [9c+8:9c].
- sync_re_o  out  CHANNELS  sync FIFO read enables, one-hot or zero.
- async_empty_i  in  CHANNELS  async FIFO empty flags.
- async_data_i  in  9*CHANNELS  async FIFO read data.
- async_re_o  out  CHANNELS  async FIFO read enables, one-hot or zero.
- sym_o  out  9  current symbol, held between strobes.
- sym_stb_o  out  1  one-clock strobe: sym_o is new.
- grant_sync_o  out  1  current grant class (1 = sync).
- grant_ch_o  out  3  current grant channel index.
- ts_o  out  1  one-clock pulse coincident with sym_stb_o when sym_o == TIMESTAMP_CODE.

Behaviour:
- Reset (rst_i low, async):
  - slot counter = 0; grant = async channel 0; async_last = 0; idle_cnt = 0.
  - sym_o = K_IDLE; sym_stb_o, ts_o, all *_re_o = 0.
- Slot counter: counts 0..DIV-1, then wraps to 0. Phases:
  - Read phase, cnt == 1: assert the re bit of the granted FIFO for exactly one clock, only if that FIFO is non-empty and its channel is enabled. Otherwise no read.
  - Capture phase, cnt == 2: FIFO data is valid here, one clock after re.
    - If a read occurred, latch the granted data into the pending register and clear idle_cnt.
    - Otherwise load K_IDLE into pending and increment idle_cnt, saturating at 15.
  - Emit phase, cnt == DIV-1: sym_o <= pending; sym_stb_o = 1; ts_o = (pending == TIMESTAMP_CODE).
    - Latency from re to sym_stb_o is DIV-2 clocks.
    - K_IDLE emission also strobes.
  - Arbitrate phase, cnt == DIV-1, same edge as emit: the new grant takes effect for the next slot's read. Empty means empty_i bit set or chan_en_i bit clear.
- Grant is async channel a:
  - If any sync channel is non-empty: async_last <= a; grant the first non-empty sync channel searching round-robin from sync_rr.
  - Else if async[a] is non-empty or idle_cnt < ASYNC_HOLD: stay.
  - Else: first non-empty async channel searching from a+1 with wrap; if none, stay.
- Grant is sync channel c:
  - If sync[c] is non-empty or idle_cnt < SYNC_HOLD: stay.
  - Else: first non-empty sync channel searching from c+1 with wrap; sync_rr <= c+1.
  - If no sync channel is non-empty: return to async async_last.
- Any grant change clears idle_cnt.
- SYNC_HOLD = 0 means release immediately on the first empty slot.
- A channel disabled mid-grant stops being read at the next read phase. Its grant is released by the normal hold rules. A read already issued completes and is emitted.
- Search arithmetic is modulo CHANNELS. grant_ch_o is zero-extended.
- Never more than one re bit high per clock; re is never asserted when the corresponding empty_i is set at that edge.
- Reset mid-slot: discard pending; the first strobe after release occurs at cnt == DIV-1 and carries K_IDLE.

Test Plan:
- Reset release, all FIFOs empty, DIV=5 -> sym_stb_o every 5 clocks, sym_o = 9'h1BC; no re; grant stays async ch0.
- Async ch0 holds 3 symbols 0x011, 0x022, 0x033 -> async_re_o[0] at cnt 1 of three consecutive slots; symbols emitted in order, each 3 clocks after its re; then K_IDLE.
- Async ch0 streaming; sync ch1 becomes non-empty with 2 symbols -> next slot grant sync ch1, both sync symbols emitted back-to-back, 2 idle slots (SYNC_HOLD), then grant returns to async ch0 and its stream resumes.
- Sync ch0 and ch1 both non-empty, 4 symbols each -> ch0 drains fully, then ch1 drains; no interleaving while the holder is non-empty; after both are empty the grant returns to async_last.
- chan_en_i = 2'b10 with async ch0 non-empty -> async_re_o[0] never asserted; only K_IDLE emitted; setting chan_en_i[0] = 1 resumes reads within one slot.
- Symbol 0x000 emitted -> ts_o = 1 on that strobe only; rst_i pulsed low at cnt 3 -> outputs return to reset values immediately.
